// File: rtl/mskaes_32bits_key_sched_ctrl_pkg.sv
// Shared types and constants for the masked AES-128 key-schedule controller.
// Used by mskaes_32bits_key_sched_ctrl and mskaes_key_sched_cnt.
package mskaes_32bits_key_sched_ctrl_pkg;

   localparam int NUM_ROUNDS = 10;
   localparam int COLS       = 4;
   localparam int ROUND_W    = 4;
   localparam int COL_W      = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PASS,
      S_SB_SEND,
      S_SB_WAIT,
      S_COL,
      S_DONE
   } state_t;

   // S-box wait-counter width is clog2(SBOX_LAT), floored at 1 so SBOX_LAT=1 still yields a legal vector
   function automatic int wait_w(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mskaes_key_sched_cnt.sv
// Round, column and S-box wait counters for the key-schedule controller.
// Each counter supports clear/load and step, and exposes a terminal-count flag.
module mskaes_key_sched_cnt
   import mskaes_32bits_key_sched_ctrl_pkg::*;
#(
   parameter int SBOX_LAT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               col_clr_i,
   input  logic               col_inc_i,
   input  logic               round_clr_i,
   input  logic               round_inc_i,
   input  logic               wait_load_i,
   input  logic               wait_dec_i,
   output logic [COL_W-1:0]   col_idx_o,
   output logic [ROUND_W-1:0] round_idx_o,
   output logic               col_last_o,
   output logic               round_last_o,
   output logic               wait_last_o
);

   localparam int WAIT_W = wait_w(SBOX_LAT);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SBOX_LAT - 1);

   logic [COL_W-1:0]   col_q, col_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;

   always_comb begin
      col_d   = col_q;
      round_d = round_q;
      wait_d  = wait_q;
      // Column counter wraps 3 -> 0 naturally at the end of each pass/round
      if (col_clr_i)        col_d = '0;
      else if (col_inc_i)   col_d = col_q + 1'b1;
      if (round_clr_i)      round_d = '0;
      else if (round_inc_i) round_d = round_q + 1'b1;
      if (wait_load_i)      wait_d = WAIT_INIT;
      else if (wait_dec_i)  wait_d = wait_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         round_q <= '0;
         wait_q  <= '0;
      end else begin
         col_q   <= col_d;
         round_q <= round_d;
         wait_q  <= wait_d;
      end
   end

   assign col_idx_o    = col_q;
   assign round_idx_o  = round_q;
   assign col_last_o   = (col_q == COL_W'(COLS - 1));
   assign round_last_o = (round_q == ROUND_W'(NUM_ROUNDS));
   assign wait_last_o  = (wait_q == WAIT_W'(1));

endmodule

// File: rtl/mskaes_32bits_key_sched_ctrl.sv
// Control FSM for the masked 32-bit AES-128 key datapath (load, round-0 pass, 10 S-box rounds).
// Define MSKAES_KEY_INVERSE_EN to support the inverse key schedule.
module mskaes_32bits_key_sched_ctrl
   import mskaes_32bits_key_sched_ctrl_pkg::*;
#(
   parameter int SBOX_LAT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_inverse,
   output logic               in_ready,
   input  logic               ak_ready,
   output logic               col_valid,
   output logic [ROUND_W-1:0] round_idx,
   output logic [COL_W-1:0]   col_idx,
   output logic               sbox_req,
   output logic               key_init,
   output logic               key_enable,
   output logic               key_loop,
   output logic               key_add_from_sb,
   output logic               rcon_rst,
   output logic               rcon_update,
   output logic               rcon_inverse,
   output logic               en_buf_sb,
   output logic               rst_buf_sb,
   output logic               done
);

   state_t state_q;
   logic   col_acc, col_last, round_last, wait_last, inv_act;

   mskaes_key_sched_cnt #(.SBOX_LAT(SBOX_LAT)) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .col_clr_i    (state_q == S_LOAD),
      .col_inc_i    (col_acc),
      .round_clr_i  ((state_q == S_LOAD) || (state_q == S_DONE)),
      .round_inc_i  (col_acc && col_last && ((state_q == S_PASS) || !round_last)),
      .wait_load_i  (state_q == S_SB_SEND),
      .wait_dec_i   (state_q == S_SB_WAIT),
      .col_idx_o    (col_idx),
      .round_idx_o  (round_idx),
      .col_last_o   (col_last),
      .round_last_o (round_last),
      .wait_last_o  (wait_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (in_valid) state_q <= S_LOAD;
            S_LOAD:    state_q <= S_PASS;
            S_PASS:    if (col_acc && col_last) state_q <= S_SB_SEND;
            S_SB_SEND: state_q <= (SBOX_LAT > 1) ? S_SB_WAIT : S_COL;
            S_SB_WAIT: if (wait_last) state_q <= S_COL;
            S_COL:     if (col_acc && col_last) state_q <= round_last ? S_DONE : S_SB_SEND;
            S_DONE:    state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

`ifdef MSKAES_KEY_INVERSE_EN
   logic inv_q;

   always_ff @(posedge clk) begin
      if (rst)                                 inv_q <= 1'b0;
      else if (state_q == S_IDLE && in_valid)  inv_q <= in_inverse;
   end

   assign inv_act = inv_q && (state_q != S_IDLE);
`else
   logic unused_in_inverse;
   assign unused_in_inverse = in_inverse;
   assign inv_act = 1'b0;
`endif

   // A column is accepted only in PASS/COL and only when the consumer is ready
   assign col_acc = col_valid && ak_ready;

   always_comb begin
      in_ready        = (state_q == S_IDLE);
      col_valid       = (state_q == S_PASS) || (state_q == S_COL);
      sbox_req        = (state_q == S_SB_SEND);
      key_init        = (state_q == S_LOAD);
      key_enable      = (state_q == S_LOAD) || (col_valid && ak_ready);
      key_loop        = (state_q == S_PASS);
      key_add_from_sb = (state_q == S_COL) && (col_idx == '0);
      rcon_rst        = (state_q == S_LOAD);
      rcon_update     = (state_q == S_COL) && col_acc && col_last;
      done            = (state_q == S_DONE);
      rcon_inverse    = inv_act;
      // Inverse mode buffers S-box output over columns 0..2; column 0 also restarts the buffer
      en_buf_sb       = inv_act && (state_q == S_COL) && col_acc && !col_last;
      rst_buf_sb      = en_buf_sb && (col_idx == '0);
   end

endmodule

// File: tb/tb_mskaes_32bits_key_sched_ctrl.sv
// Directed bench for mskaes_32bits_key_sched_ctrl: SBOX_LAT=4 and SBOX_LAT=1 instances share stimulus.
`define CHECK(tag, obs, exp) \
   begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end end

module tb_mskaes_32bits_key_sched_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_valid, in_inverse, ak_ready;

   logic       in_ready_a, col_valid_a, sbox_req_a, key_init_a, key_enable_a, key_loop_a;
   logic       key_add_from_sb_a, rcon_rst_a, rcon_update_a, rcon_inverse_a, en_buf_sb_a, rst_buf_sb_a, done_a;
   logic [3:0] round_idx_a;
   logic [1:0] col_idx_a;
   logic       in_ready_b, col_valid_b, sbox_req_b, key_init_b, key_enable_b, key_loop_b;
   logic       key_add_from_sb_b, rcon_rst_b, rcon_update_b, rcon_inverse_b, en_buf_sb_b, rst_buf_sb_b, done_b;
   logic [3:0] round_idx_b;
   logic [1:0] col_idx_b;

   mskaes_32bits_key_sched_ctrl #(.SBOX_LAT(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_inverse(in_inverse), .in_ready(in_ready_a),
      .ak_ready(ak_ready), .col_valid(col_valid_a), .round_idx(round_idx_a), .col_idx(col_idx_a),
      .sbox_req(sbox_req_a), .key_init(key_init_a), .key_enable(key_enable_a), .key_loop(key_loop_a),
      .key_add_from_sb(key_add_from_sb_a), .rcon_rst(rcon_rst_a), .rcon_update(rcon_update_a),
      .rcon_inverse(rcon_inverse_a), .en_buf_sb(en_buf_sb_a), .rst_buf_sb(rst_buf_sb_a), .done(done_a)
   );

   mskaes_32bits_key_sched_ctrl #(.SBOX_LAT(1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_inverse(in_inverse), .in_ready(in_ready_b),
      .ak_ready(ak_ready), .col_valid(col_valid_b), .round_idx(round_idx_b), .col_idx(col_idx_b),
      .sbox_req(sbox_req_b), .key_init(key_init_b), .key_enable(key_enable_b), .key_loop(key_loop_b),
      .key_add_from_sb(key_add_from_sb_b), .rcon_rst(rcon_rst_b), .rcon_update(rcon_update_b),
      .rcon_inverse(rcon_inverse_b), .en_buf_sb(en_buf_sb_b), .rst_buf_sb(rst_buf_sb_b), .done(done_b)
   );

   logic [11:0] ctrl_a;
   assign ctrl_a = {col_valid_a, sbox_req_a, key_init_a, key_enable_a, key_loop_a, key_add_from_sb_a,
                    rcon_rst_a, rcon_update_a, rcon_inverse_a, en_buf_sb_a, rst_buf_sb_a, done_a};

   int checks = 0;
   int errors = 0;

   int load_cyc, colv_cnt, loop_cnt, addsb_cnt, sb_cnt, sb_first, sb_last, sb_gap_bad;
   int ru_cnt, ru_bad, done_cyc, ready_cyc, rinv_cnt, rinv_first, rinv_last;
   int enbuf_cnt, enbuf_bad, rstbuf_cnt, rstbuf_bad, stall_cyc, stall_bad;
   int done1_cyc, sb1_cnt, col0_after_sb1;

   // One full schedule from a start pulse, observed for 95 cycles (cycle 1 = LOAD)
   task automatic run_sched(input bit do_stall, input bit inv);
      int  stall_left = 0;
      bit  stalled = 1'b0;
      bit  prev_sb1 = 1'b0;
      load_cyc = -1; colv_cnt = 0; loop_cnt = 0; addsb_cnt = 0; sb_cnt = 0; sb_first = -1; sb_last = 0;
      sb_gap_bad = 0; ru_cnt = 0; ru_bad = 0; done_cyc = -1; ready_cyc = -1; rinv_cnt = 0;
      rinv_first = -1; rinv_last = -1; enbuf_cnt = 0; enbuf_bad = 0; rstbuf_cnt = 0; rstbuf_bad = 0;
      stall_cyc = 0; stall_bad = 0; done1_cyc = -1; sb1_cnt = 0; col0_after_sb1 = 0;
      @(negedge clk);
      in_valid = 1'b1; in_inverse = inv; ak_ready = 1'b1;
      for (int c = 1; c <= 95; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (do_stall && !stalled && round_idx_a == 4'd5 && col_idx_a == 2'd2 && col_valid_a) begin
            stalled = 1'b1;
            stall_left = 3;
         end
         ak_ready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            stall_cyc++;
            stall_left--;
            if (col_idx_a != 2'd2 || key_enable_a || rcon_update_a || !col_valid_a) stall_bad++;
         end
         if (key_init_a) load_cyc = c;
         if (col_valid_a) colv_cnt++;
         if (key_loop_a) loop_cnt++;
         if (key_add_from_sb_a) addsb_cnt++;
         if (sbox_req_a) begin
            if (sb_cnt == 0) sb_first = c;
            else if (c - sb_last != 8) sb_gap_bad++;
            sb_last = c;
            sb_cnt++;
         end
         if (rcon_update_a) begin
            ru_cnt++;
            if (c < 13 || ((c - 13) % 8) != 0) ru_bad++;
         end
         if (done_a) done_cyc = c;
         if (in_ready_a && ready_cyc < 0) ready_cyc = c;
         if (rcon_inverse_a) begin
            rinv_cnt++;
            if (rinv_first < 0) rinv_first = c;
            rinv_last = c;
         end
         if (en_buf_sb_a) begin
            enbuf_cnt++;
            if (col_idx_a == 2'd3 || !key_enable_a) enbuf_bad++;
         end
         if (rst_buf_sb_a) begin
            rstbuf_cnt++;
            if (col_idx_a != 2'd0 || !en_buf_sb_a) rstbuf_bad++;
         end
         if (done_b) done1_cyc = c;
         if (sbox_req_b) sb1_cnt++;
         if (prev_sb1 && col_valid_b && col_idx_b == 2'd0) col0_after_sb1++;
         prev_sb1 = sbox_req_b;
      end
      $display("schedule stall=%0d inv=%0d: load=%0d done=%0d ready=%0d sbox=%0d rcon_upd=%0d col_valid=%0d",
               do_stall, inv, load_cyc, done_cyc, ready_cyc, sb_cnt, ru_cnt, colv_cnt);
   endtask

   initial begin
      bit found;
      rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; ak_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk); #1;
      `CHECK("reset_in_ready", in_ready_a, 1'b1)
      `CHECK("reset_ctrl", ctrl_a, 12'h000)
      `CHECK("reset_round_idx", round_idx_a, 4'd0)
      `CHECK("reset_col_idx", col_idx_a, 2'd0)
      $display("reset: in_ready=%0d ctrl=%h", in_ready_a, ctrl_a);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);

      // Nominal forward schedule
      run_sched(1'b0, 1'b0);
      `CHECK("nom_load_cycle", load_cyc, 1)
      `CHECK("nom_col_valid_cycles", colv_cnt, 44)
      `CHECK("nom_key_loop_cycles", loop_cnt, 4)
      `CHECK("nom_add_from_sb_cycles", addsb_cnt, 10)
      `CHECK("nom_sbox_req_count", sb_cnt, 10)
      `CHECK("nom_sbox_req_first", sb_first, 6)
      `CHECK("nom_sbox_req_gap", sb_gap_bad, 0)
      `CHECK("nom_rcon_update_count", ru_cnt, 10)
      `CHECK("nom_rcon_update_cycles", ru_bad, 0)
      `CHECK("nom_done_cycle", done_cyc, 86)
      `CHECK("nom_in_ready_return", ready_cyc, 87)
      `CHECK("nom_rcon_inverse_cycles", rinv_cnt, 0)
      `CHECK("lat1_done_cycle", done1_cyc, 56)
      `CHECK("lat1_sbox_req_count", sb1_cnt, 10)
      `CHECK("lat1_col0_after_send", col0_after_sb1, 10)

      // Backpressure at round 5 column 2
      run_sched(1'b1, 1'b0);
      `CHECK("stall_cycles", stall_cyc, 3)
      `CHECK("stall_hold", stall_bad, 0)
      `CHECK("stall_done_cycle", done_cyc, 89)
      `CHECK("stall_rcon_update_count", ru_cnt, 10)
      `CHECK("stall_col_valid_cycles", colv_cnt, 47)

`ifdef MSKAES_KEY_INVERSE_EN
      run_sched(1'b0, 1'b1);
      `CHECK("inv_rcon_inverse_first", rinv_first, 1)
      `CHECK("inv_rcon_inverse_last", rinv_last, 86)
      `CHECK("inv_rcon_inverse_cycles", rinv_cnt, 86)
      `CHECK("inv_en_buf_count", enbuf_cnt, 30)
      `CHECK("inv_en_buf_columns", enbuf_bad, 0)
      `CHECK("inv_rst_buf_count", rstbuf_cnt, 10)
      `CHECK("inv_rst_buf_columns", rstbuf_bad, 0)
      `CHECK("inv_done_cycle", done_cyc, 86)
`else
      run_sched(1'b0, 1'b1);
      `CHECK("noinv_done_cycle", done_cyc, 86)
      `CHECK("noinv_rcon_update_cycles", ru_bad, 0)
      `CHECK("noinv_col_valid_cycles", colv_cnt, 44)
      `CHECK("noinv_rcon_inverse_cycles", rinv_cnt, 0)
      `CHECK("noinv_en_buf_count", enbuf_cnt, 0)
      `CHECK("noinv_rst_buf_count", rstbuf_cnt, 0)
`endif

      // Reset in SB_WAIT of round 3, then a fresh full schedule
      @(negedge clk);
      in_valid = 1'b1; in_inverse = 1'b0; ak_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      found = 1'b0;
      for (int c = 2; c <= 60 && !found; c++) begin
         @(posedge clk); #1;
         if (round_idx_a == 4'd3 && !col_valid_a && !sbox_req_a && !in_ready_a) found = 1'b1;
      end
      `CHECK("midrst_sbwait_reached", found, 1'b1)
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      `CHECK("midrst_in_ready", in_ready_a, 1'b1)
      `CHECK("midrst_ctrl", ctrl_a, 12'h000)
      `CHECK("midrst_round_idx", round_idx_a, 4'd0)
      `CHECK("midrst_col_idx", col_idx_a, 2'd0)
      $display("mid-run reset: in_ready=%0d ctrl=%h round=%0d", in_ready_a, ctrl_a, round_idx_a);
      run_sched(1'b0, 1'b0);
      `CHECK("midrst_restart_done", done_cyc, 86)
      `CHECK("midrst_restart_ready", ready_cyc, 87)

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
